// File: rtl/calc_cmd_sequencer_if.sv
// Command/response and calculator byte-bus bundle for calc_cmd_sequencer.
// slave = sequencer side, master = environment side.
interface calc_cmd_sequencer_if #(
  parameter int WORD_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [WORD_WIDTH-1:0]   cmd_a;
  logic [WORD_WIDTH-1:0]   cmd_b;
  logic [2:0]              cmd_op;
  logic                    calc_iniciar;
  logic [WORD_WIDTH-1:0]   calc_dados;
  logic                    calc_pronto;
  logic [RESULT_WIDTH-1:0] calc_result;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [RESULT_WIDTH-1:0] rsp_result;
  logic                    rsp_timeout;
  logic                    busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  calc_pronto, calc_result, rsp_ready,
    output cmd_ready, calc_iniciar, calc_dados,
    output rsp_valid, rsp_result, rsp_timeout, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output calc_pronto, calc_result, rsp_ready,
    input  cmd_ready, calc_iniciar, calc_dados,
    input  rsp_valid, rsp_result, rsp_timeout, busy
  );
endinterface

// File: rtl/calc_cmd_sequencer.sv
// Serialises one-beat calculator commands onto iniciar/dados, waits for pronto.
// Optional CALC_SEQ_STATS_EN adds saturating command/timeout counters.
module calc_cmd_sequencer #(
  parameter int WORD_WIDTH     = 8,
  parameter int RESULT_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef CALC_SEQ_STATS_EN
  output logic [15:0]           stat_cmds,
  output logic [15:0]           stat_timeouts,
`endif
  calc_cmd_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, START, SEND_A, SEND_B,
    SEND_OP, WAIT_DONE, RESP
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic [WORD_WIDTH-1:0]   a_q;
  logic [WORD_WIDTH-1:0]   b_q;
  logic [2:0]              op_q;
  logic [7:0]              cnt;
  logic                    cmd_ready_q;
  logic                    iniciar_q;
  logic [WORD_WIDTH-1:0]   dados_q;
  logic                    rsp_valid_q;
  logic [RESULT_WIDTH-1:0] result_q;
  logic                    timeout_q;
  logic                    busy_q;

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.calc_iniciar = iniciar_q;
  assign bus.calc_dados   = dados_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = result_q;
  assign bus.rsp_timeout  = timeout_q;
  assign bus.busy         = busy_q;

  // Outputs are set on the transition into the state that presents them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt         <= '0;
      cmd_ready_q <= 1'b1;
      iniciar_q   <= 1'b0;
      dados_q     <= '0;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            a_q         <= bus.cmd_a;
            b_q         <= bus.cmd_b;
            op_q        <= bus.cmd_op;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            iniciar_q   <= 1'b1;
            dados_q     <= '0;
            state       <= START;
          end
        end
        START: begin
          iniciar_q <= 1'b0;
          dados_q   <= a_q;
          state     <= SEND_A;
        end
        SEND_A: begin
          dados_q <= b_q;
          state   <= SEND_B;
        end
        SEND_B: begin
          dados_q <= {{(WORD_WIDTH-3){1'b0}}, op_q};
          state   <= SEND_OP;
        end
        SEND_OP: begin
          dados_q <= '0;
          cnt     <= '0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt <= cnt + 8'd1;
          if (bus.calc_pronto) begin
            result_q    <= bus.calc_result;
            timeout_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (cnt == LAST) begin
            result_q    <= '0;
            timeout_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CALC_SEQ_STATS_EN
  logic accept_ev;
  logic tmo_ev;

  assign accept_ev = (state == IDLE) && bus.cmd_valid;
  assign tmo_ev    = (state == WAIT_DONE) && !bus.calc_pronto
                     && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cmds     <= '0;
      stat_timeouts <= '0;
    end else begin
      if (accept_ev && stat_cmds != 16'hFFFF)
        stat_cmds <= stat_cmds + 16'd1;
      if (tmo_ev && stat_timeouts != 16'hFFFF)
        stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed + randomized bench for calc_cmd_sequencer.
// A behavioural calculator answers on the byte bus; expectations come from the command timeline.
module tb_calc_cmd_sequencer;
  localparam int W = 8;
  localparam int R = 16;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total = 0;
  int   exp_cmds = 0;
  int   exp_tmo = 0;

`ifdef CALC_SEQ_STATS_EN
  logic [15:0] stat_cmds;
  logic [15:0] stat_timeouts;
`endif

  calc_cmd_sequencer_if #(.WORD_WIDTH(W), .RESULT_WIDTH(R)) bus ();

  calc_cmd_sequencer #(
    .WORD_WIDTH(W), .RESULT_WIDTH(R), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef CALC_SEQ_STATS_EN
    .stat_cmds(stat_cmds),
    .stat_timeouts(stat_timeouts),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Behavioural calculator: 4-bit operands, 3-bit opcode.
  function automatic logic [15:0] calc_fn(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic [2:0] op);
    logic [15:0] x;
    logic [15:0] y;
    x = {12'd0, a};
    y = {12'd0, b};
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x * y;
      3'd3: return x & y;
      3'd4: return x | y;
      3'd5: return x ^ y;
      3'd6: return x << 2;
      default: return {8'd0, a, b};
    endcase
  endfunction

  // d = WAIT_DONE cycle (1-based) in which pronto rises; outside 1..T means never.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input int d, input int hold);
    logic [7:0]  seen [3];
    logic [15:0] expr;
    logic        tmo;
    tmo  = !(d >= 1 && d <= T);
    expr = tmo ? 16'd0 : calc_fn(a[3:0], b[3:0], op);
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    bus.cmd_valid = 1'b1;
    tick();
    exp_cmds++;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = 8'($urandom);
    bus.cmd_b = 8'($urandom);
    bus.cmd_op = 3'($urandom);
    check("start_iniciar", 32'(bus.calc_iniciar), 32'd1);
    check("start_dados", 32'(bus.calc_dados), 32'd0);
    check("start_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("start_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      seen[i] = bus.calc_dados;
      check("send_iniciar", 32'(bus.calc_iniciar), 32'd0);
    end
    check("dados_a", 32'(seen[0]), 32'(a));
    check("dados_b", 32'(seen[1]), 32'(b));
    check("dados_op", 32'(seen[2]), 32'(op));
    for (int k = 1; k <= T; k++) begin
      tick();
      check("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("wait_dados", 32'(bus.calc_dados), 32'd0);
      bus.calc_pronto = (k == d);
      bus.calc_result = (k == d) ?
        calc_fn(seen[0][3:0], seen[1][3:0], seen[2][2:0]) : 16'($urandom);
      if (k == d) break;
    end
    tick();
    bus.calc_pronto = 1'b0;
    bus.calc_result = 16'($urandom);
    if (tmo) exp_tmo++;
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_result", 32'(bus.rsp_result), 32'(expr));
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'(tmo));
    bus.rsp_ready = (hold == 0);
    for (int i = 1; i <= hold; i++) begin
      tick();
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rsp_result", 32'(bus.rsp_result), 32'(expr));
      check("hold_rsp_timeout", 32'(bus.rsp_timeout), 32'(tmo));
      check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      if (i == hold) bus.rsp_ready = 1'b1;
    end
    tick();
    bus.rsp_ready = 1'b0;
    check("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_iniciar"}, 32'(bus.calc_iniciar), 32'd0);
    check({tag, "_dados"}, 32'(bus.calc_dados), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
    check({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    bus.calc_pronto = 1'b0;
    bus.calc_result = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_cmd(8'd3, 8'd4, 3'd0, 2, 0);
    run_cmd(8'd12, 8'd5, 3'd2, 2, 5);
    run_cmd(8'd7, 8'd1, 3'd1, 0, 0);
    run_cmd(8'hA6, 8'h3B, 3'd7, 2, 0);
    run_cmd(8'd15, 8'd15, 3'd2, T, 1);

    for (int i = 0; i < 4; i++) begin
      bus.calc_pronto = 1'b1;
      bus.calc_result = 16'($urandom);
      tick();
      check("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("stray_busy", 32'(bus.busy), 32'd0);
    end
    bus.calc_pronto = 1'b0;
    tick();

    bus.cmd_a = 8'd5;
    bus.cmd_b = 8'd6;
    bus.cmd_op = 3'd0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_dados_b", 32'(bus.calc_dados), 32'd6);
    rst_n = 1'b0;
    #1;
    exp_cmds = 0;
    exp_tmo = 0;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    run_cmd(8'd9, 8'd1, 3'd0, 2, 0);

    for (int n = 0; n < 24; n++) begin
      run_cmd(8'($urandom), 8'($urandom), 3'($urandom),
              int'($urandom_range(1, T + 2)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) tick();
    end

`ifdef CALC_SEQ_STATS_EN
    check("stat_cmds", 32'(stat_cmds), 32'(exp_cmds));
    check("stat_timeouts", 32'(stat_timeouts), 32'(exp_tmo));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
